// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package adder_seq_pkg;
   localparam int   BYTE_W = 8;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/adder88.sv
// 8-bit adder with carry in/out; the sequencer's only arithmetic resource.
module adder88 (
   output logic       cout,
   output logic [7:0] z,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin
);
   assign {cout, z} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner on accept.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt,
   output logic       prio
);
   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
   end

   // gnt is one-hot when accepted, so gnt[1] is the winner's index
   always_ff @(posedge clk) begin
      if (rst)                  prio <= 1'b0;
      else if (accept && |gnt)  prio <= ~gnt[1];
   end
endmodule

// File: rtl/adder_sequencer.sv
// Multi-byte add/subtract engine: two requesters share one 8-bit adder,
// operands are walked LSB byte first with the carry held between bytes.
module adder_sequencer
   import adder_seq_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  op0,
   input  logic [BYTE_W*WORDS-1:0] a0,
   input  logic [BYTE_W*WORDS-1:0] b0,
   input  logic                  req1,
   input  logic                  op1,
   input  logic [BYTE_W*WORDS-1:0] a1,
   input  logic [BYTE_W*WORDS-1:0] b1,
   output logic                  ack0,
   output logic                  ack1,
   output logic                  busy,
   output logic                  done,
   output logic [BYTE_W*WORDS-1:0] result,
   output logic                  cout,
   output logic                  owner
);
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef struct packed {
      logic                              op;
      logic [WORDS-1:0][BYTE_W-1:0] a;
      logic [WORDS-1:0][BYTE_W-1:0] b;
   } opnd_t;

   state_t                       state;
   opnd_t                        cur;
   logic                         carry;
   logic [IW-1:0]                idx;
   logic [WORDS-1:0][BYTE_W-1:0] acc, acc_nxt;
   logic [1:0]                   gnt;
   logic                         accept, prio;
   logic [BYTE_W-1:0]            add_a, add_b, add_z;
   logic                         add_co;

   assign accept = (state == IDLE) && (req0 || req1);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({req1, req0}),
      .accept (accept),
      .gnt    (gnt),
      .prio   (prio)
   );

   // subtract feeds ~b; the +1 comes from carry being seeded with op
   assign add_a = cur.a[idx];
   assign add_b = cur.b[idx] ^ {BYTE_W{cur.op}};

   adder88 u_add (
      .cout (add_co),
      .z    (add_z),
      .a    (add_a),
      .b    (add_b),
      .cin  (carry)
   );

   always_comb begin
      acc_nxt      = acc;
      acc_nxt[idx] = add_z;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         owner  <= 1'b0;
         carry  <= 1'b0;
         idx    <= '0;
         cur    <= '0;
         acc    <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               cur   <= gnt[1] ? {op1, a1, b1} : {op0, a0, b0};
               carry <= gnt[1] ? op1 : op0;
               owner <= gnt[1];
               idx   <= '0;
               ack0  <= gnt[0];
               ack1  <= gnt[1];
               busy  <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               acc   <= acc_nxt;
               carry <= add_co;
               idx   <= idx + 1'b1;
               if (idx == IW'(WORDS - 1)) begin
                  result <= acc_nxt;
                  cout   <= add_co;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
